// File: rtl/alarm_watch_p.sv
// alarm_watch_p: 24-hour HH:MM:SS watch with set modes, an HH:MM alarm,
// a fixed-length ring and snooze. User buttons are one-cycle pulses that
// have already been debounced. Only one button acts per cycle, in the order
// mode > sel > inc > dec.
//
// Handshake note: there is no valid/ready traffic here. Every button input is
// a single-cycle strobe sampled on the rising clk edge, and alarm_en is a level.
module alarm_watch_p #(
  parameter int TICK_DIV   = 4,
  parameter int ALARM_LEN  = 10,
  parameter int SNOOZE_MIN = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       mode,
  input  logic       sel,
  input  logic       inc,
  input  logic       dec,
  input  logic       alarm_en,
  input  logic       snooze,
  output logic [4:0] hrs,
  output logic [5:0] mins,
  output logic [5:0] sec,
  output logic [4:0] al_hrs,
  output logic [5:0] al_mins,
  output logic [2:0] state,
  output logic       alarm
);

  localparam int            PW        = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [5:0]    RING_LEN  = 6'(ALARM_LEN);
  localparam logic [6:0]    SNZ_ADD   = 7'(SNOOZE_MIN);

  typedef enum logic [2:0] {
    RUN   = 3'd0,
    SET_H = 3'd1,
    SET_M = 3'd2,
    SET_S = 3'd3,
    AL_H  = 3'd4,
    AL_M  = 3'd5
  } state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          tick_q;
  logic [4:0]    hrs_q, hrs_d;
  logic [5:0]    mins_q, mins_d;
  logic [5:0]    sec_q, sec_d;
  logic [4:0]    al_hrs_q, al_hrs_d;
  logic [5:0]    al_mins_q, al_mins_d;
  logic [4:0]    snz_h_q, snz_h_d;
  logic [5:0]    snz_m_q, snz_m_d;
  logic          snz_pend_q, snz_pend_d;
  logic [5:0]    ring_cnt_q, ring_cnt_d;
  logic          alarm_q, alarm_d;

  logic       act_inc, act_dec;
  logic       run_now, run_next, tick;
  logic       at_alarm, at_snooze, trig;
  logic [6:0] snz_sum;

  // Modular +1/-1 over 0..max_v, used for every edited field.
  function automatic logic [5:0] step_mod(input logic [5:0] v, input logic [5:0] max_v,
                                          input logic up);
    if (up) return (v == max_v) ? 6'd0 : v + 6'd1;
    else    return (v == 6'd0) ? max_v : v - 6'd1;
  endfunction

  // Button arbitration and mode/field navigation; stray encodings fall back to RUN.
  always_comb begin
    state_d = state_q;
    act_inc = !mode && !sel && inc;
    act_dec = !mode && !sel && !inc && dec;
    if (mode) begin
      case (state_q)
        RUN:                 state_d = SET_H;
        SET_H, SET_M, SET_S: state_d = AL_H;
        default:             state_d = RUN;
      endcase
    end else if (sel) begin
      case (state_q)
        SET_H:   state_d = SET_M;
        SET_M:   state_d = SET_S;
        SET_S:   state_d = SET_H;
        AL_H:    state_d = AL_M;
        AL_M:    state_d = AL_H;
        default: state_d = RUN;
      endcase
    end else begin
      case (state_q)
        RUN, SET_H, SET_M, SET_S, AL_H, AL_M: state_d = state_q;
        default:                              state_d = RUN;
      endcase
    end
  end

  // Seconds prescaler: runs in RUN and alarm-edit modes, parked at 0 while setting time.
  always_comb begin
    run_now  = (state_q == RUN) || (state_q == AL_H) || (state_q == AL_M);
    run_next = (state_d == RUN) || (state_d == AL_H) || (state_d == AL_M);
    tick     = run_now && (presc_q == PRESC_MAX);
    presc_d  = '0;
    if (run_now && run_next && !tick) presc_d = presc_q + PW'(1);
  end

  // Timekeeping with carries on tick; field edits (no carry) only on non-tick cycles.
  always_comb begin
    hrs_d     = hrs_q;
    mins_d    = mins_q;
    sec_d     = sec_q;
    al_hrs_d  = al_hrs_q;
    al_mins_d = al_mins_q;
    if (tick) begin
      if (sec_q == 6'd59) begin
        sec_d = 6'd0;
        if (mins_q == 6'd59) begin
          mins_d = 6'd0;
          hrs_d  = (hrs_q == 5'd23) ? 5'd0 : hrs_q + 5'd1;
        end else begin
          mins_d = mins_q + 6'd1;
        end
      end else begin
        sec_d = sec_q + 6'd1;
      end
    end else if (act_inc || act_dec) begin
      case (state_q)
        SET_H:   hrs_d     = 5'(step_mod({1'b0, hrs_q}, 6'd23, act_inc));
        SET_M:   mins_d    = step_mod(mins_q, 6'd59, act_inc);
        SET_S:   sec_d     = step_mod(sec_q, 6'd59, act_inc);
        AL_H:    al_hrs_d  = 5'(step_mod({1'b0, al_hrs_q}, 6'd23, act_inc));
        AL_M:    al_mins_d = step_mod(al_mins_q, 6'd59, act_inc);
        default: ;
      endcase
    end
  end

  // Ring control: cancel beats trigger, trigger beats snooze, snooze beats countdown.
  always_comb begin
    ring_cnt_d = ring_cnt_q;
    snz_pend_d = snz_pend_q;
    snz_h_d    = snz_h_q;
    snz_m_d    = snz_m_q;
    snz_sum    = {1'b0, mins_q} + SNZ_ADD;
    at_alarm   = (hrs_q == al_hrs_q) && (mins_q == al_mins_q);
    at_snooze  = snz_pend_q && (hrs_q == snz_h_q) && (mins_q == snz_m_q);
    trig       = tick_q && (state_q == RUN) && alarm_en && (sec_q == 6'd0) &&
                 (at_alarm || at_snooze);
    if (!alarm_en || (state_q != RUN)) begin
      ring_cnt_d = 6'd0;
      snz_pend_d = 1'b0;
    end else if (trig) begin
      ring_cnt_d = RING_LEN;
      snz_pend_d = 1'b0;
    end else if (snooze && alarm_q) begin
      ring_cnt_d = 6'd0;
      snz_pend_d = 1'b1;
      if (snz_sum >= 7'd60) begin
        snz_m_d = 6'(snz_sum - 7'd60);
        snz_h_d = (hrs_q == 5'd23) ? 5'd0 : hrs_q + 5'd1;
      end else begin
        snz_m_d = snz_sum[5:0];
        snz_h_d = hrs_q;
      end
    end else if (tick && (ring_cnt_q != 6'd0)) begin
      ring_cnt_d = ring_cnt_q - 6'd1;
    end
    alarm_d = (ring_cnt_d != 6'd0);
  end

  // State registers with asynchronous active-high reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= RUN;
      presc_q    <= '0;
      tick_q     <= 1'b0;
      hrs_q      <= 5'd0;
      mins_q     <= 6'd0;
      sec_q      <= 6'd0;
      al_hrs_q   <= 5'd0;
      al_mins_q  <= 6'd0;
      snz_h_q    <= 5'd0;
      snz_m_q    <= 6'd0;
      snz_pend_q <= 1'b0;
      ring_cnt_q <= 6'd0;
      alarm_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      presc_q    <= presc_d;
      tick_q     <= tick;
      hrs_q      <= hrs_d;
      mins_q     <= mins_d;
      sec_q      <= sec_d;
      al_hrs_q   <= al_hrs_d;
      al_mins_q  <= al_mins_d;
      snz_h_q    <= snz_h_d;
      snz_m_q    <= snz_m_d;
      snz_pend_q <= snz_pend_d;
      ring_cnt_q <= ring_cnt_d;
      alarm_q    <= alarm_d;
    end
  end

  assign hrs     = hrs_q;
  assign mins    = mins_q;
  assign sec     = sec_q;
  assign al_hrs  = al_hrs_q;
  assign al_mins = al_mins_q;
  assign state   = state_q;
  assign alarm   = alarm_q;

endmodule
